// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder: one 10-bit symbol per pixel clock, two-stage pipeline.
// Stage 1 registers the pixel and its popcount; stage 2 does transition minimisation and DC balancing.
module tmds_encoder #(
    parameter int CNT_WIDTH = 5
) (
    input  logic       clkp,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       de,
    input  logic [1:0] c,
    output logic [9:0] tmds
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic signed [CNT_WIDTH-1:0] C_ZERO  = '0;
    localparam logic signed [CNT_WIDTH-1:0] C_TWO   = CNT_WIDTH'(2);
    localparam logic signed [CNT_WIDTH-1:0] C_EIGHT = CNT_WIDTH'(8);
    localparam logic signed [CNT_WIDTH-1:0] C_TEN   = CNT_WIDTH'(10);

    logic [7:0]                  r_data;
    logic                        r_de;
    logic [1:0]                  r_c;
    logic [3:0]                  r_n1d;
    logic signed [CNT_WIDTH-1:0] r_cnt;
    logic [9:0]                  r_tmds;

    logic                        w_use_xnor;
    logic [8:0]                  w_qm;
    logic [3:0]                  w_n1;
    logic signed [CNT_WIDTH-1:0] w_diff;
    logic signed [CNT_WIDTH-1:0] w_two;
    logic signed [CNT_WIDTH-1:0] w_two_n;
    logic [9:0]                  w_tmds_next;
    logic signed [CNT_WIDTH-1:0] w_cnt_next;

    function automatic logic [8:0] f_qm(input logic [7:0] d, input logic use_xnor);
        logic [8:0] q;
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    always_ff @(posedge clkp or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_de   <= 1'b0;
            r_c    <= 2'b00;
            r_n1d  <= '0;
        end else begin
            r_data <= data;
            r_de   <= de;
            r_c    <= c;
            r_n1d  <= 4'($countones(data));
        end
    end

    assign w_use_xnor = (r_n1d > 4'd4) || (r_n1d == 4'd4 && !r_data[0]);
    assign w_qm       = f_qm(r_data, w_use_xnor);
    assign w_n1       = 4'($countones(w_qm[7:0]));
    // N1 - N0 == 2*N1 - 8; modular arithmetic keeps this exact at any CNT_WIDTH >= 5
    assign w_diff     = $signed(CNT_WIDTH'({w_n1, 1'b0})) - C_EIGHT;
    assign w_two      = w_qm[8] ? C_TWO : C_ZERO;
    assign w_two_n    = w_qm[8] ? C_ZERO : C_TWO;

    always_comb begin
        w_tmds_next = CTRL_00;
        w_cnt_next  = C_ZERO;
        if (!r_de) begin
            unique case (r_c)
                2'b00:   w_tmds_next = CTRL_00;
                2'b01:   w_tmds_next = CTRL_01;
                2'b10:   w_tmds_next = CTRL_10;
                default: w_tmds_next = CTRL_11;
            endcase
        end else if (r_cnt == C_ZERO || w_n1 == 4'd4) begin
            w_tmds_next = {~w_qm[8], w_qm[8], w_qm[8] ? w_qm[7:0] : ~w_qm[7:0]};
            w_cnt_next  = w_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if ((!r_cnt[CNT_WIDTH-1] && w_n1 > 4'd4) ||
                     ( r_cnt[CNT_WIDTH-1] && w_n1 < 4'd4)) begin
            w_tmds_next = {1'b1, w_qm[8], ~w_qm[7:0]};
            w_cnt_next  = r_cnt + w_two - w_diff;
        end else begin
            w_tmds_next = {1'b0, w_qm[8], w_qm[7:0]};
            w_cnt_next  = r_cnt - w_two_n + w_diff;
        end
    end

    always_ff @(posedge clkp or posedge rst) begin
        if (rst) begin
            r_tmds <= CTRL_00;
            r_cnt  <= C_ZERO;
        end else begin
            assert (r_cnt <= C_TEN && r_cnt >= -C_TEN);
            r_tmds <= w_tmds_next;
            r_cnt  <= w_cnt_next;
        end
    end

    assign tmds = r_tmds;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: directed DVI cases plus a random soak against an arithmetic reference
// model, with every output symbol also run through an inverse TMDS decoder.
module tb_tmds_encoder;

    logic       clkp;
    logic       rst;
    logic [7:0] data;
    logic       de;
    logic [1:0] c;
    logic [9:0] tmds;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] ctrl_codes [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    int         m_cnt;
    logic [7:0] h_d;
    logic       h_e;
    logic [1:0] h_c;
    logic [7:0] last_d;
    logic       last_e;
    logic [1:0] last_c;
    logic [9:0] exp_sym;

    tmds_encoder #(.CNT_WIDTH(5)) dut (
        .clkp (clkp),
        .rst  (rst),
        .data (data),
        .de   (de),
        .c    (c),
        .tmds (tmds)
    );

    initial clkp = 1'b0;
    always #5 clkp = ~clkp;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] ref_encode(input logic [7:0] d, input logic e, input logic [1:0] cc);
        logic [8:0] qm;
        logic       use_xnor;
        int         n1d, n1, n0;
        logic [9:0] sym;
        if (!e) begin
            m_cnt = 0;
            return ctrl_codes[cc];
        end
        n1d      = $countones(d);
        use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        n1    = $countones(qm[7:0]);
        n0    = 8 - n1;
        if (m_cnt == 0 || n1 == n0) begin
            sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            m_cnt = m_cnt + (qm[8] ? (n1 - n0) : (n0 - n1));
        end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
            sym   = {1'b1, qm[8], ~qm[7:0]};
            m_cnt = m_cnt + (qm[8] ? 2 : 0) + (n0 - n1);
        end else begin
            sym   = {1'b0, qm[8], qm[7:0]};
            m_cnt = m_cnt - (qm[8] ? 0 : 2) + (n1 - n0);
        end
        return sym;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] sym);
        logic [7:0] v;
        logic [7:0] d;
        v    = sym[9] ? ~sym[7:0] : sym[7:0];
        d    = '0;
        d[0] = v[0];
        for (int i = 1; i < 8; i++)
            d[i] = sym[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        return d;
    endfunction

    task automatic model_reset();
        h_d   = '0;
        h_e   = 1'b0;
        h_c   = 2'b00;
        m_cnt = 0;
    endtask

    task automatic step(input logic [7:0] d, input logic e, input logic [1:0] cc);
        data = d;
        de   = e;
        c    = cc;
        @(posedge clkp);
        exp_sym = ref_encode(h_d, h_e, h_c);
        last_d  = h_d;
        last_e  = h_e;
        last_c  = h_c;
        h_d     = d;
        h_e     = e;
        h_c     = cc;
        @(negedge clkp);
        check("model", tmds, exp_sym);
    endtask

    task automatic step_k(input logic [7:0] d, input logic e, input logic [1:0] cc,
                          input string tag, input logic [9:0] k);
        step(d, e, cc);
        check(tag, tmds, k);
    endtask

    task automatic check_decode();
        logic [2:0] dc;
        if (last_e) begin
            check("decode_data", {2'b00, decode(tmds)}, {2'b00, last_d});
        end else begin
            dc = 3'b100;
            for (int i = 0; i < 4; i++)
                if (ctrl_codes[i] == tmds) dc = 3'(i);
            check("decode_ctrl", {7'b0, dc}, {8'b0, last_c});
        end
    endtask

    initial begin
        rst  = 1'b1;
        data = '0;
        de   = 1'b0;
        c    = 2'b00;
        model_reset();
        #1;
        check("rst_async", tmds, 10'h354);
        repeat (3) @(negedge clkp);
        check("rst_hold", tmds, 10'h354);
        rst = 1'b0;

        // control codes after release
        step_k(8'h00, 1'b0, 2'b00, "refill0", 10'h354);
        step_k(8'h00, 1'b0, 2'b01, "refill1", 10'h354);
        step_k(8'h00, 1'b0, 2'b10, "ctl01",   10'h0AB);
        step_k(8'h00, 1'b0, 2'b11, "ctl10",   10'h154);
        step_k(8'h00, 1'b0, 2'b00, "ctl11",   10'h2AB);

        // zero run
        step(8'h00, 1'b0, 2'b00);
        step(8'h00, 1'b0, 2'b00);
        step_k(8'h00, 1'b1, 2'b00, "zr_blank", 10'h354);
        step_k(8'h00, 1'b1, 2'b00, "zr0", 10'h100);
        step_k(8'h00, 1'b1, 2'b00, "zr1", 10'h3FF);
        step_k(8'h00, 1'b1, 2'b00, "zr2", 10'h100);
        step_k(8'h00, 1'b0, 2'b00, "zr3", 10'h3FF);

        // all ones from cnt = 0
        step_k(8'hFF, 1'b1, 2'b00, "ones_blank", 10'h354);
        step_k(8'h00, 1'b0, 2'b00, "ones", 10'h200);

        // blanking clears disparity
        step(8'h00, 1'b1, 2'b00);
        step_k(8'h00, 1'b1, 2'b00, "bl_zr0", 10'h100);
        step_k(8'h00, 1'b1, 2'b00, "bl_zr1", 10'h3FF);
        step_k(8'h00, 1'b0, 2'b00, "bl_zr2", 10'h100);
        step_k(8'h00, 1'b1, 2'b00, "bl_gap", 10'h354);
        step_k(8'h00, 1'b0, 2'b00, "bl_post", 10'h100);

        // asynchronous reset in the middle of active video
        for (int i = 0; i < 6; i++) step(8'($urandom), 1'b1, 2'b00);
        rst = 1'b1;
        #1;
        check("rst_mid_async", tmds, 10'h354);
        model_reset();
        repeat (2) @(negedge clkp);
        check("rst_mid_hold", tmds, 10'h354);
        rst = 1'b0;
        step_k(8'hA5, 1'b1, 2'b00, "rst_mid_refill", 10'h354);
        step(8'h3C, 1'b1, 2'b00);

        // random soak
        for (int i = 0; i < 20000; i++) begin
            step(8'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom));
            check_decode();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
